// File: rtl/mesh_tg_pkg.sv
// Shared types, packet field widths and helpers for the mesh_traffic_gen block.
// The optional PAYLOAD_TAG_EN macro (see mesh_traffic_gen.sv) changes the payload layout.
package mesh_tg_pkg;

   typedef enum logic [2:0] {
      MODE_RANDOM    = 3'd0,
      MODE_SRC_BURST = 3'd1,
      MODE_ID_BURST  = 3'd2,
      MODE_EVEN_LOAD = 3'd3,
      MODE_SELF      = 3'd4
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_e;

   // Header layout from the MSB down: next-jump, row, column, routing-mode bit
   localparam int unsigned JUMP_W = 8;
   localparam int unsigned ROW_W  = 4;
   localparam int unsigned COL_W  = 4;
   localparam int unsigned HDR_W  = JUMP_W + ROW_W + COL_W + 1;

   localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
   localparam logic [31:0] LFSR_RESET = 32'h0000_0001;

   // Bit offset of the second LFSR-derived terminal index (destination pick)
   localparam int unsigned IDX2_LSB = 16;

   function automatic logic [ROW_W+COL_W-1:0] term_coord(
      input logic [31:0] idx,
      input int unsigned rows,
      input int unsigned colums
   );
      logic [31:0] r;
      logic [31:0] c;
      if (idx < colums) begin
         r = '0;
         c = idx + 1;
      end else if (idx < 2 * colums) begin
         r = rows + 1;
         c = idx - colums + 1;
      end else if (idx < 2 * colums + rows) begin
         r = idx - 2 * colums + 1;
         c = '0;
      end else begin
         r = idx - 2 * colums - rows + 1;
         c = colums + 1;
      end
      return {ROW_W'(r), COL_W'(c)};
   endfunction

endpackage

// File: rtl/mesh_tg_lfsr.sv
// 32-bit Galois LFSR (right-shifting form) with synchronous load and advance enables.
// A zero seed is replaced by 1 so the register never locks up.
module mesh_tg_lfsr
   import mesh_tg_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        advance,
   input  logic [31:0] seed,
   output logic [31:0] state
);

   logic [31:0] stepped;

   always_comb begin
      stepped = state >> 1;
      if (state[0]) begin
         stepped = stepped ^ LFSR_POLY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LFSR_RESET;
      end else if (load) begin
         state <= (seed == '0) ? LFSR_RESET : seed;
      end else if (advance) begin
         state <= stepped;
      end
   end

endmodule

// File: rtl/mesh_traffic_gen.sv
// Traffic generator driving every edge terminal of the mesh_gnrtr router.
// Define PAYLOAD_TAG_EN to carry {issuing index, sequence number} in the payload instead of LFSR bits.
module mesh_traffic_gen
   import mesh_tg_pkg::*;
#(
   parameter int unsigned ROWS    = 4,
   parameter int unsigned COLUMS  = 4,
   parameter int unsigned PCKG_SZ = 40,
   parameter int unsigned NTERM   = 2 * ROWS + 2 * COLUMS,
   parameter int unsigned IDX_W   = $clog2(NTERM),
   parameter int unsigned NUM_W   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [2:0]               cfg_mode,
   input  logic [IDX_W-1:0]         cfg_src,
   input  logic [3:0]               cfg_row,
   input  logic [3:0]               cfg_col,
   input  logic [NUM_W-1:0]         cfg_num,
   input  logic [7:0]               cfg_gap,
   input  logic                     cfg_rmode,
   input  logic                     cfg_rmode_rand,
   input  logic [31:0]              seed,
   output logic [NTERM*PCKG_SZ-1:0] data_out,
   output logic [NTERM-1:0]         pndng,
   input  logic [NTERM-1:0]         pop,
   output logic                     busy,
   output logic                     done,
   output logic [NUM_W-1:0]         issued_cnt,
   output logic                     proto_err
);

   localparam int unsigned PL_W = PCKG_SZ - HDR_W;

   if (PCKG_SZ < HDR_W + 1) begin : g_size_chk
      $error("mesh_traffic_gen: PCKG_SZ must be at least 18");
   end
`ifdef PAYLOAD_TAG_EN
   if (PL_W < IDX_W + NUM_W) begin : g_tag_chk
      $error("mesh_traffic_gen: payload too narrow for PAYLOAD_TAG_EN tag");
   end
`endif

   state_e                 state;
   state_e                 state_nxt;
   logic [31:0]            lfsr;
   logic [7:0]             gap_cnt;
   logic [IDX_W-1:0]       rr;
   logic [NTERM-1:0]       pndng_r;
   logic [NTERM-1:0]       pndng_d;
   logic [PCKG_SZ-1:0]     slot [NTERM];
   logic [NUM_W-1:0]       issued_r;
   logic                   proto_r;

   logic                   run_start;
   logic [IDX_W-1:0]       idx_a;
   logic [IDX_W-1:0]       idx_b;
   logic [IDX_W:0]         cand;
   logic                   scan_hit;
   logic [IDX_W-1:0]       scan_ch;
   logic [IDX_W-1:0]       sel;
   logic                   sel_ok;
   logic                   issue;
   logic [ROW_W+COL_W-1:0] dest;
   logic                   rmode_bit;
   logic [PL_W-1:0]        payload;
   logic [PCKG_SZ-1:0]     pkt;
   logic                   lfsr_unused;

   function automatic logic [IDX_W-1:0] reduce_idx(input logic [IDX_W-1:0] raw);
      if ({1'b0, raw} >= (IDX_W+1)'(NTERM)) begin
         return raw - IDX_W'(NTERM);
      end
      return raw;
   endfunction

   assign run_start = start && (state == S_IDLE || state == S_DONE);

   mesh_tg_lfsr u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .load    (run_start),
      .advance (state == S_RUN),
      .seed    (seed),
      .state   (lfsr)
   );

   // Bits not consumed by the index/payload taps in a given build
   assign lfsr_unused = ^lfsr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
         S_RUN:          if (issued_r == cfg_num) state_nxt = S_DRAIN;
         S_DRAIN:        if (pndng_r == '0) state_nxt = S_DONE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == S_RUN) || (state == S_DRAIN);
      done = (state == S_DONE);
   end

   // Channel selection; occupancy is judged on the registered pndng only
   always_comb begin
      idx_a    = reduce_idx(lfsr[IDX_W-1:0]);
      idx_b    = reduce_idx(lfsr[IDX2_LSB +: IDX_W]);
      scan_hit = 1'b0;
      scan_ch  = rr;
      cand     = '0;
      for (int unsigned i = 0; i < NTERM; i++) begin
         cand = {1'b0, rr} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(NTERM)) begin
            cand = cand - (IDX_W+1)'(NTERM);
         end
         if (!scan_hit && !pndng_r[cand[IDX_W-1:0]]) begin
            scan_hit = 1'b1;
            scan_ch  = cand[IDX_W-1:0];
         end
      end

      sel    = idx_a;
      sel_ok = 1'b1;
      dest   = term_coord(32'(idx_b), ROWS, COLUMS);
      case (cfg_mode)
         MODE_SRC_BURST: begin
            sel    = cfg_src;
            sel_ok = ({1'b0, cfg_src} < (IDX_W+1)'(NTERM));
         end
         MODE_ID_BURST: begin
            sel    = scan_ch;
            sel_ok = scan_hit;
            dest   = {cfg_row, cfg_col};
         end
         MODE_SELF: begin
            sel    = scan_ch;
            sel_ok = scan_hit;
            dest   = term_coord(32'(scan_ch), ROWS, COLUMS);
         end
         MODE_EVEN_LOAD: begin
            sel    = rr;
         end
         default: begin
            sel    = idx_a;
         end
      endcase

      issue = (state == S_RUN) && (gap_cnt == '0) && (issued_r != cfg_num)
              && sel_ok && !pndng_r[sel];

      rmode_bit = cfg_rmode_rand ? lfsr[31] : cfg_rmode;
`ifdef PAYLOAD_TAG_EN
      payload = PL_W'({sel, issued_r});
`else
      payload = PL_W'(lfsr);
`endif
      pkt = {JUMP_W'(0), dest, rmode_bit, payload};

      pndng_d = pndng_r & ~pop;
      if (issue) begin
         pndng_d[sel] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pndng_r  <= '0;
         issued_r <= '0;
         gap_cnt  <= '0;
         rr       <= '0;
         proto_r  <= 1'b0;
         for (int unsigned k = 0; k < NTERM; k++) begin
            slot[k] <= '0;
         end
      end else begin
         pndng_r <= pndng_d;
         proto_r <= proto_r | (|(pop & ~pndng_r));
         if (run_start) begin
            issued_r <= '0;
            gap_cnt  <= '0;
         end else if (issue) begin
            issued_r  <= issued_r + 1'b1;
            gap_cnt   <= cfg_gap;
            rr        <= (sel == IDX_W'(NTERM - 1)) ? '0 : sel + 1'b1;
            slot[sel] <= pkt;
         end else if (state == S_RUN && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NTERM; k++) begin : g_out
      assign data_out[k*PCKG_SZ +: PCKG_SZ] = slot[k];
   end

   assign pndng      = pndng_r;
   assign issued_cnt = issued_r;
   assign proto_err  = proto_r;

endmodule
